// File: rtl/fifo_pkg.sv
// Constants and state encoding shared by the word FIFO and its serial transmitter.
package fifo_pkg;

  localparam int FIFO_DATA_W = 6;
  localparam int FIFO_DEPTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/fifo_tx_serializer_if.sv
// FIFO read port: the serializer (master) pops and the FIFO (slave) supplies registered data.
interface fifo_tx_serializer_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);

endinterface

// File: rtl/fifo_tx_bit_timer.sv
// Serial bit-period timer; bit_tick marks the last clk of each bit period.
module fifo_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops FIFO words and sends each as start, LSB-first data, optional even parity, stop.
module fifo_tx_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_W       = FIFO_DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_enable,
  fifo_tx_serializer_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shifted;
  logic [IDX_W-1:0]  bit_idx;
  logic              parity;
  logic              bit_tick;
  logic              timer_clear;

  assign shifted     = shift_reg >> 1;
  assign timer_clear = !(state inside {START, DATA, PARITY, STOP});
  assign frame_done  = (state == STOP) && bit_tick;

  fifo_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  // tx is loaded with the value of the state being entered, so it is valid from that state's first cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_idx         <= '0;
      parity          <= 1'b0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      fifo.fifo_rd_en <= 1'b0;
    end else begin
      fifo.fifo_rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_enable && !fifo.fifo_empty) begin
            state           <= POP;
            fifo.fifo_rd_en <= 1'b1;
            busy            <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo.fifo_data;
          parity    <= ^fifo.fifo_data;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              shift_reg <= shifted;
              tx        <= shifted[0];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
